ocext_wrr_arbiter: RTL
======================

OCEXT_WRR_ARBITER -- requirements
Module: ocext_wrr_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters; legal range 2..32.
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-port weight field.
REQ-003 SHALL have parameter LSB_HIGH_PRIORITY, default 0; 1 makes index 0 first choice in the round-robin scan, 0 makes index PORTS-1 first choice.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-006 SHALL have port request, input, PORTS, per-port request level.
REQ-007 SHALL have port acknowledge, input, PORTS, per-port completion pulse (one transfer per cycle high).
REQ-008 SHALL have port weight, input, PORTS*WEIGHT_W, port i weight in bits [i*WEIGHT_W +: WEIGHT_W], quasi-static.
REQ-009 SHALL have port grant, output, PORTS, one-hot grant (registered).
REQ-010 SHALL have port grant_valid, output, 1, grant is meaningful (registered).
REQ-011 SHALL have port grant_encoded, output, $clog2(PORTS), index of granted port (registered).
REQ-012 SHALL have port grant_count, output, PORTS*16, per-port saturating grant counters (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE and OWNED; IDLE = grant_valid 0, OWNED = grant_valid 1.
REQ-014 IDLE: any request bit set SHALL produce grant/grant_valid/grant_encoded on the next cycle (1-cycle latency); no request keeps IDLE.
REQ-015 On entering OWNED for port p, credit SHALL load weight[p]; weight 0 SHALL be treated as 1.
REQ-016 OWNED: grant SHALL hold, regardless of request, until acknowledge[p] is 1; acknowledge on non-granted ports SHALL be ignored.
REQ-017 On acknowledge[p], credit SHALL decrement; if credit-1 > 0 and request[p] = 1, grant SHALL stay on p.
REQ-018 Otherwise, the next requester after p in round-robin order (wrapping) SHALL be granted on the next cycle with no bubble; credit reloads for the new port.
REQ-019 If p is the only requester when its credit exhausts, p SHALL be re-granted with credit reloaded from weight[p].
REQ-020 If no port requests at the acknowledge cycle, the FSM SHALL return to IDLE next cycle with grant = 0, grant_encoded = 0.
REQ-021 The round-robin pointer SHALL advance only on a change of owner, never on a credit-continued grant.
REQ-022 Credit counter width SHALL be WEIGHT_W; no over/underflow SHALL occur.

Reset
REQ-023 rst assertion SHALL immediately clear grant, grant_valid, grant_encoded, credit, pointer (first choice per REQ-003) and grant_count; FSM = IDLE.
REQ-024 Reset mid-transfer SHALL abandon the owner; after deassertion the first grant SHALL obey REQ-014.

Configuration
REQ-025 Macro OCEXT_WRR_ARBITER_STATS_EN defined: grant_count[i] SHALL increment (saturating at 16'hFFFF) each cycle acknowledge[i] is accepted for the granted port i.
REQ-026 Macro undefined: grant_count SHALL be constant 0 and no counter flops SHALL be built; arbitration behaviour SHALL be identical.

Structure
REQ-027 Package ocext_wrr_arbiter_pkg SHALL hold the FSM state enum and the grant_count width constant (16).
REQ-028 Masked/unmasked next-requester selection SHALL use two instances of ocext_priority_encoder.

Verification
REQ-029 PORTS=4, weights {1,1,1,1}, request=4'b1111, ack every owned cycle, LSB_HIGH_PRIORITY=1 -> grant_encoded 0,1,2,3,0 on consecutive acknowledges, no bubble.
REQ-030 Weights port0=3, port1=1, request=4'b0011, ack every cycle -> grant sequence 0,0,0,1,0,0,0,1.
REQ-031 Only port2 requests, weight 2, 5 acks -> grant stays on port2 throughout, grant_valid never drops.
REQ-032 Port1 granted, request[1] drops with no ack for 10 cycles -> grant holds on port1; ack then with request=0 -> IDLE next cycle, grant=0.
REQ-033 rst pulsed mid-OWNED asynchronously (between clock edges) -> outputs 0 before next edge; post-reset request=4'b1000 -> grant=4'b1000 one cycle later.
REQ-034 STATS_EN defined, 70000 acks to port0 -> grant_count[0] = 16'hFFFF; macro undefined -> grant_count = 0.

Source files
------------

// File: rtl/ocext_wrr_arbiter_pkg.sv
// Shared types and constants for the weighted round-robin arbiter.
// Optional statistics counters are enabled by defining OCEXT_WRR_ARBITER_STATS_EN.
package ocext_wrr_arbiter_pkg;

    // Arbiter FSM: IDLE means no grant is outstanding, OWNED means one port holds the grant.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Width of each per-port grant counter.
    localparam int COUNT_W = 16;

endpackage

// File: rtl/ocext_priority_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the index of the
// winning bit (lowest index when LSB_HIGH_PRIORITY != 0, highest otherwise).
module ocext_priority_encoder
    import ocext_wrr_arbiter_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         request,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] index
);

    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the lowest-priority end so the highest-priority set bit is assigned last.
    always_comb begin
        valid = |request;
        index = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            int unsigned j;
            j = (LSB_HIGH_PRIORITY != 0) ? (WIDTH - 1 - i) : i;
            if (request[j]) begin
                index = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ocext_wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant, credit-based
// multi-transfer ownership and wrap-around round-robin hand-over.
// Define OCEXT_WRR_ARBITER_STATS_EN to build the per-port saturating grant counters;
// without it grant_count is tied to zero and no counter flops exist.
module ocext_wrr_arbiter
    import ocext_wrr_arbiter_pkg::*;
#(
    parameter int PORTS             = 4,
    parameter int WEIGHT_W          = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS-1:0]           request,
    input  logic [PORTS-1:0]           acknowledge,
    input  logic [PORTS*WEIGHT_W-1:0]  weight,
    output logic [PORTS-1:0]           grant,
    output logic                       grant_valid,
    output logic [$clog2(PORTS)-1:0]   grant_encoded,
    output logic [PORTS*COUNT_W-1:0]   grant_count
);

    localparam int IDX_W = $clog2(PORTS);
    localparam logic [IDX_W-1:0] FIRST_CHOICE =
        (LSB_HIGH_PRIORITY != 0) ? '0 : IDX_W'(PORTS - 1);
    localparam logic [PORTS-1:0] ONE_HOT_0 = PORTS'(1);

    arb_state_t           state;
    logic [IDX_W-1:0]     pointer;
    logic [WEIGHT_W-1:0]  credit;

    logic [PORTS-1:0]     mask;
    logic [PORTS-1:0]     masked_request;
    logic                 masked_valid;
    logic [IDX_W-1:0]     masked_index;
    logic                 full_valid;
    logic [IDX_W-1:0]     full_index;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_index;
    logic [IDX_W-1:0]     pick_next_pointer;
    logic [WEIGHT_W-1:0]  pick_weight;
    logic [WEIGHT_W-1:0]  pick_credit;
    logic                 owner_ack;
    logic                 owner_continue;

    // Ports at or beyond the pointer in scan order form the preferred (masked) set.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (LSB_HIGH_PRIORITY != 0) begin
                mask[i] = (IDX_W'(i) >= pointer);
            end else begin
                mask[i] = (IDX_W'(i) <= pointer);
            end
        end
        masked_request = request & mask;
    end

    ocext_priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_pe_masked (
        .request (masked_request),
        .valid   (masked_valid),
        .index   (masked_index)
    );

    ocext_priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_pe_full (
        .request (request),
        .valid   (full_valid),
        .index   (full_index)
    );

    // Next owner choice, its reload credit (weight 0 acts as 1) and the pointer that follows it.
    always_comb begin
        pick_valid  = full_valid;
        pick_index  = masked_valid ? masked_index : full_index;
        pick_weight = weight[int'(pick_index)*WEIGHT_W +: WEIGHT_W];
        pick_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
        if (LSB_HIGH_PRIORITY != 0) begin
            pick_next_pointer = (pick_index == IDX_W'(PORTS - 1)) ? '0 : pick_index + IDX_W'(1);
        end else begin
            pick_next_pointer = (pick_index == '0) ? IDX_W'(PORTS - 1) : pick_index - IDX_W'(1);
        end
        owner_ack      = acknowledge[grant_encoded];
        owner_continue = (credit > WEIGHT_W'(1)) && request[grant_encoded];
    end

    // Arbitration FSM with registered grant outputs, credit and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            credit        <= '0;
            pointer       <= FIRST_CHOICE;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state         <= OWNED;
                        grant         <= ONE_HOT_0 << pick_index;
                        grant_valid   <= 1'b1;
                        grant_encoded <= pick_index;
                        credit        <= pick_credit;
                        pointer       <= pick_next_pointer;
                    end
                end
                OWNED: begin
                    if (owner_ack) begin
                        if (owner_continue) begin
                            credit <= credit - WEIGHT_W'(1);
                        end else if (pick_valid) begin
                            // The pointer already sits after the owner, so a sole requester wraps back to itself.
                            grant         <= ONE_HOT_0 << pick_index;
                            grant_encoded <= pick_index;
                            credit        <= pick_credit;
                            pointer       <= pick_next_pointer;
                        end else begin
                            state         <= IDLE;
                            grant         <= '0;
                            grant_valid   <= 1'b0;
                            grant_encoded <= '0;
                            credit        <= '0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef OCEXT_WRR_ARBITER_STATS_EN
    logic [COUNT_W-1:0] counts [PORTS];

    // Count accepted transfers per port, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                counts[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if ((state == OWNED) && grant[i] && acknowledge[i] && (counts[i] != '1)) begin
                    counts[i] <= counts[i] + COUNT_W'(1);
                end
            end
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            grant_count[i*COUNT_W +: COUNT_W] = counts[i];
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule
